// File: rtl/add_32_issue_arbiter_if.sv
// Bundles the slot request, adder operand/result and response signals of the add arbiter.
// Latency: none (wires only).
// Backpressure: req_valid/req_ready handshake on the request side; responses cannot be stalled.
interface add_32_issue_arbiter_if #(
    parameter int N_REQ = 4,
    parameter int W     = 32
);
    // issue-slot requests
    logic [N_REQ-1:0]   req_valid;
    logic [N_REQ*W-1:0] req_a;
    logic [N_REQ*W-1:0] req_b;
    logic [N_REQ-1:0]   req_cin;
    logic [N_REQ-1:0]   req_ready;
    // operands towards the shared adder
    logic [W-1:0]       add_a;
    logic [W-1:0]       add_b;
    logic               add_cin;
    logic               add_issue;
    // results returning from the shared adder
    logic [W-1:0]       add_sum;
    logic               add_cout;
    // responses back to the issuing slot
    logic [N_REQ-1:0]   resp_valid;
    logic [W-1:0]       resp_sum;
    logic               resp_cout;
    // status
    logic               busy;
    logic [15:0]        issue_cnt;

    // arbiter view
    modport slave (
        input  req_valid, req_a, req_b, req_cin, add_sum, add_cout,
        output req_ready, add_a, add_b, add_cin, add_issue,
               resp_valid, resp_sum, resp_cout, busy, issue_cnt
    );

    // view of the slots plus adder that surround the arbiter
    modport master (
        output req_valid, req_a, req_b, req_cin, add_sum, add_cout,
        input  req_ready, add_a, add_b, add_cin, add_issue,
               resp_valid, resp_sum, resp_cout, busy, issue_cnt
    );
endinterface

// File: rtl/add_32_issue_arbiter.sv
// Round-robin shares one pipelined W-bit adder among N_REQ issue slots and routes results back by tag.
// Latency: grant cycle T -> operands at T+1 -> resp_valid at T+2+LAT (6 cycles at defaults).
// Backpressure: a slot stalls only when it has MAX_OUT ops in flight; responses are never stalled.
module add_32_issue_arbiter #(
    parameter int N_REQ   = 4,
    parameter int LAT     = 4,
    parameter int MAX_OUT = 3,
    parameter int W       = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    add_32_issue_arbiter_if.slave bus
);

    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int OW = $clog2(MAX_OUT + 1);

    // arbitration state
    logic [PW-1:0]    r_ptr;
    logic [OW-1:0]    r_outst [N_REQ];
    logic [N_REQ-1:0] w_elig;
    logic             w_gnt_vld;
    logic [PW-1:0]    w_gnt_idx;
    logic [N_REQ-1:0] w_gnt;

    // operand register feeding the adder, with the id of the op it holds
    logic [W-1:0]     r_add_a;
    logic [W-1:0]     r_add_b;
    logic             r_add_cin;
    logic             r_add_issue;
    logic [PW-1:0]    r_add_id;

    // tag pipe mirroring the adder stages
    logic [LAT-1:0]   r_tag_v;
    logic [PW-1:0]    r_tag_id [LAT];
    logic [N_REQ-1:0] w_resp_load;

    // response register and status
    logic [N_REQ-1:0] r_resp_valid;
    logic [W-1:0]     r_resp_sum;
    logic             r_resp_cout;
    logic [15:0]      r_issue_cnt;

    // A slot may compete only while it still has credit for another op in flight.
    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            w_elig[i] = bus.req_valid[i] && (r_outst[i] < OW'(MAX_OUT));
        end
    end

    // Round-robin pick: first eligible slot at or after the pointer, wrapping; nothing while in reset.
    always_comb begin : rr_pick
        int w_idx;
        w_idx     = 0;
        w_gnt_vld = 1'b0;
        w_gnt_idx = '0;
        for (int k = 0; k < N_REQ; k++) begin
            w_idx = int'(r_ptr) + k;
            if (w_idx >= N_REQ) begin
                w_idx = w_idx - N_REQ;
            end
            if (!w_gnt_vld && w_elig[w_idx]) begin
                w_gnt_vld = 1'b1;
                w_gnt_idx = w_idx[PW-1:0];
            end
        end
        if (!reset) begin
            w_gnt_vld = 1'b0;
        end
        w_gnt = '0;
        if (w_gnt_vld) begin
            w_gnt[w_gnt_idx] = 1'b1;
        end
    end

    // Decode the tag leaving the last stage; it lines up with add_sum/add_cout this cycle.
    always_comb begin
        w_resp_load = '0;
        if (r_tag_v[LAT-1]) begin
            w_resp_load[r_tag_id[LAT-1]] = 1'b1;
        end
    end

    // Advance the pointer past the winner; hold it when nobody is granted.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ptr <= '0;
        end else if (w_gnt_vld) begin
            if (int'(w_gnt_idx) == N_REQ - 1) begin
                r_ptr <= '0;
            end else begin
                r_ptr <= w_gnt_idx + PW'(1);
            end
        end
    end

    // Per-slot credit: +1 on grant, -1 on the edge that raises that slot's resp_valid,
    // so the freed credit is already visible in the cycle the response is presented.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < N_REQ; i++) begin
                r_outst[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_REQ; i++) begin
                if (w_gnt[i] && !w_resp_load[i]) begin
                    r_outst[i] <= r_outst[i] + OW'(1);
                end else if (!w_gnt[i] && w_resp_load[i]) begin
                    r_outst[i] <= r_outst[i] - OW'(1);
                end
            end
        end
    end

    // Capture the winner's operands; operands hold when idle so the adder inputs stay quiet.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_add_a     <= '0;
            r_add_b     <= '0;
            r_add_cin   <= 1'b0;
            r_add_issue <= 1'b0;
            r_add_id    <= '0;
        end else begin
            r_add_issue <= w_gnt_vld;
            if (w_gnt_vld) begin
                r_add_a   <= bus.req_a[w_gnt_idx*W +: W];
                r_add_b   <= bus.req_b[w_gnt_idx*W +: W];
                r_add_cin <= bus.req_cin[w_gnt_idx];
                r_add_id  <= w_gnt_idx;
            end
        end
    end

    // Tag pipe shifts every cycle, matching the non-stallable adder stage for stage.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_tag_v <= '0;
            for (int k = 0; k < LAT; k++) begin
                r_tag_id[k] <= '0;
            end
        end else begin
            r_tag_v[0]  <= r_add_issue;
            r_tag_id[0] <= r_add_id;
            for (int k = 1; k < LAT; k++) begin
                r_tag_v[k]  <= r_tag_v[k-1];
                r_tag_id[k] <= r_tag_id[k-1];
            end
        end
    end

    // Register the result for its owner; the data holds between responses.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_resp_valid <= '0;
            r_resp_sum   <= '0;
            r_resp_cout  <= 1'b0;
        end else begin
            r_resp_valid <= w_resp_load;
            if (r_tag_v[LAT-1]) begin
                r_resp_sum  <= bus.add_sum;
                r_resp_cout <= bus.add_cout;
            end
        end
    end

    // Count grants since reset, wrapping naturally at 16 bits.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_issue_cnt <= '0;
        end else if (w_gnt_vld) begin
            r_issue_cnt <= r_issue_cnt + 16'd1;
        end
    end

    assign bus.req_ready  = w_gnt;
    assign bus.add_a      = r_add_a;
    assign bus.add_b      = r_add_b;
    assign bus.add_cin    = r_add_cin;
    assign bus.add_issue  = r_add_issue;
    assign bus.resp_valid = r_resp_valid;
    assign bus.resp_sum   = r_resp_sum;
    assign bus.resp_cout  = r_resp_cout;
    assign bus.busy       = (|r_tag_v) | (|r_resp_valid) | r_add_issue;
    assign bus.issue_cnt  = r_issue_cnt;

endmodule
